// File: rtl/icmp_echo_req_rx.sv
// icmp_echo_req_rx
// Receives ICMP packets from the IP RX payload stream, validates echo
// requests (type 8, code 0, unfragmented, length in range, byte count and
// optionally the ICMP checksum) and pulses o_trigger with the captured
// Identifier/Sequence so the echo-reply generator can answer.
// Optional build macro: ICMP_RX_CHECKSUM_EN
//   defined     -> ones-complement checksum accumulated and verified
//   not defined -> no accumulator, checksum treated as good; latency unchanged
module icmp_echo_req_rx #(
   parameter int P_MAX_LEN  = 1480,
   parameter int P_TRIG_GAP = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] s_axis_ip_data,
   input  logic [55:0] s_axis_ip_user,
   input  logic [7:0]  s_axis_ip_keep,
   input  logic        s_axis_ip_last,
   input  logic        s_axis_ip_valid,
   output logic        s_axis_ip_ready,
   output logic [15:0] o_Identifier,
   output logic [15:0] o_Sequence,
   output logic        o_trigger,
   output logic [15:0] o_rx_cnt,
   output logic [15:0] o_drop_cnt
);

   // Gap counter wide enough to hold P_TRIG_GAP-1
   localparam int GAP_W = (P_TRIG_GAP > 2) ? $clog2(P_TRIG_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(P_TRIG_GAP - 1);
   localparam logic [15:0] MAX_LEN16 = 16'(P_MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DISCARD,
      ST_FOLD1,
      ST_FOLD2,
      ST_DECIDE
   } state_t;

   state_t state_reg, state_next;

   // Sideband fields carried with every beat
   logic [15:0] user_len;
   logic        user_mf;
   logic [7:0]  user_proto;
   logic [12:0] user_offset;

   assign user_len    = s_axis_ip_user[55:40];
   assign user_mf     = s_axis_ip_user[37];
   assign user_proto  = s_axis_ip_user[36:29];
   assign user_offset = s_axis_ip_user[28:16];

   // IP ID and the two upper flag bits play no part in echo validation
   logic unused_user_bits;
   assign unused_user_bits = ^{s_axis_ip_user[39:38], s_axis_ip_user[15:0]};

   logic        beat_fire;
   logic        first_ok;
   logic [3:0]  beat_bytes;
   logic        decide_pass;
   logic        drop_evt;
   logic        csum_ok;

   logic [16:0]      byte_cnt_reg;
   logic [15:0]      len_reg;
   logic [15:0]      id_reg;
   logic [15:0]      seq_reg;
   logic [GAP_W-1:0] gap_reg;

   assign beat_fire = s_axis_ip_valid && s_axis_ip_ready;

   // Header checks applied to the first beat of every packet
   assign first_ok = (user_proto == 8'd1) &&
                     (user_offset == 13'd0) &&
                     !user_mf &&
                     (s_axis_ip_data[63:56] == 8'd8) &&
                     (s_axis_ip_data[55:48] == 8'd0) &&
                     (user_len >= 16'd8) &&
                     (user_len <= MAX_LEN16);

   // Number of valid bytes in the current beat
   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < 8; i++) begin
         beat_bytes = beat_bytes + {3'b000, s_axis_ip_keep[i]};
      end
   end

`ifdef ICMP_RX_CHECKSUM_EN
   logic [63:0] masked_data;
   logic [17:0] beat_sum;
   logic [31:0] acc_reg;

   // Bytes outside keep are zeroed so an odd tail byte is padded low
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_mask
         assign masked_data[gi*8 +: 8] = s_axis_ip_keep[gi] ? s_axis_ip_data[gi*8 +: 8] : 8'h00;
      end
   endgenerate

   assign beat_sum = {2'b00, masked_data[63:48]} + {2'b00, masked_data[47:32]} +
                     {2'b00, masked_data[31:16]} + {2'b00, masked_data[15:0]};

   // Checksum accumulator: restart on first beat, add per beat, fold twice
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE:  if (beat_fire) acc_reg <= 32'(beat_sum);
            ST_ACCUM: if (beat_fire) acc_reg <= acc_reg + 32'(beat_sum);
            ST_FOLD1,
            ST_FOLD2: acc_reg <= {16'h0000, acc_reg[31:16]} + {16'h0000, acc_reg[15:0]};
            default:  ;
         endcase
      end
   end

   assign csum_ok = (acc_reg == 32'h0000_FFFF);
`else
   // Without the checksum engine the middle data words are not inspected
   logic unused_csum_bits;
   assign unused_csum_bits = ^s_axis_ip_data[47:32];
   assign csum_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // Next state, ready and per-packet verdict
   always_comb begin
      state_next      = state_reg;
      s_axis_ip_ready = 1'b0;
      decide_pass     = 1'b0;
      drop_evt        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            s_axis_ip_ready = !i_rst;
            if (beat_fire) begin
               if (!first_ok) begin
                  // A rejected single-beat packet is dropped right away
                  drop_evt   = s_axis_ip_last;
                  state_next = s_axis_ip_last ? ST_IDLE : ST_DISCARD;
               end else begin
                  state_next = s_axis_ip_last ? ST_FOLD1 : ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            s_axis_ip_ready = !i_rst;
            if (beat_fire && s_axis_ip_last) state_next = ST_FOLD1;
         end
         ST_DISCARD: begin
            s_axis_ip_ready = !i_rst;
            if (beat_fire && s_axis_ip_last) begin
               drop_evt   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_FOLD1: state_next = ST_FOLD2;
         ST_FOLD2: state_next = ST_DECIDE;
         ST_DECIDE: begin
            decide_pass = (byte_cnt_reg == {1'b0, len_reg}) && csum_ok && (gap_reg == '0);
            drop_evt    = !decide_pass;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Packet capture, byte counting, reply trigger, gap timer and counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         byte_cnt_reg <= '0;
         len_reg      <= '0;
         id_reg       <= '0;
         seq_reg      <= '0;
         gap_reg      <= '0;
         o_Identifier <= '0;
         o_Sequence   <= '0;
         o_trigger    <= 1'b0;
         o_rx_cnt     <= '0;
         o_drop_cnt   <= '0;
      end else begin
         o_trigger <= 1'b0;

         if (beat_fire) begin
            if (state_reg == ST_IDLE) begin
               len_reg      <= user_len;
               id_reg       <= s_axis_ip_data[31:16];
               seq_reg      <= s_axis_ip_data[15:0];
               byte_cnt_reg <= 17'(beat_bytes);
            end else if (state_reg == ST_ACCUM) begin
               byte_cnt_reg <= byte_cnt_reg + 17'(beat_bytes);
            end
         end

         // A reply is only requested once the previous one has had its window
         if (decide_pass) begin
            o_Identifier <= id_reg;
            o_Sequence   <= seq_reg;
            o_trigger    <= 1'b1;
            o_rx_cnt     <= o_rx_cnt + 16'd1;
            gap_reg      <= GAP_LOAD;
         end else if (gap_reg != '0) begin
            gap_reg <= gap_reg - 1'b1;
         end

         if (drop_evt) o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_icmp_echo_req_rx.sv
// Testbench for icmp_echo_req_rx: table of packet vectors plus hand-written
// sequences (latency, reply gap, reset mid-packet), checked via a scoreboard.
`timescale 1ns/1ps
module tb_icmp_echo_req_rx;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [63:0] s_data  = '0;
   logic [55:0] s_user  = '0;
   logic [7:0]  s_keep  = '0;
   logic        s_last  = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] o_id, o_seq, o_rx, o_drop;
   logic        o_trig;

   always #5 i_clk = ~i_clk;

   icmp_echo_req_rx #(.P_MAX_LEN(1480), .P_TRIG_GAP(8)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .s_axis_ip_data  (s_data),
      .s_axis_ip_user  (s_user),
      .s_axis_ip_keep  (s_keep),
      .s_axis_ip_last  (s_last),
      .s_axis_ip_valid (s_valid),
      .s_axis_ip_ready (s_ready),
      .o_Identifier    (o_id),
      .o_Sequence      (o_seq),
      .o_trigger       (o_trig),
      .o_rx_cnt        (o_rx),
      .o_drop_cnt      (o_drop)
   );

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          trig;
      logic [15:0] id;
      logic [15:0] seq;
   } exp_t;
   exp_t sb_q[$];

   int          exp_rx = 0, exp_drop = 0, txn = 0;
   logic [15:0] last_id = '0, last_seq = '0;
   int          last_cyc = -100, trig_cyc = -1;
   logic [15:0] prev_drop = '0;

   logic [7:0]  pkt [0:1535];
   int          pkt_n = 0;
   logic [55:0] pkt_user = '0;
   bit          bubbles = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
      end
   endtask

   // Internet checksum of pkt[0..n-1] (odd tail padded with a zero low byte)
   function automatic logic [15:0] inet_csum(input int n);
      logic [31:0] s;
      logic [15:0] w;
      s = '0;
      for (int i = 0; i < n; i += 2) begin
         w[15:8] = pkt[i];
         w[7:0]  = (i + 1 < n) ? pkt[i+1] : 8'h00;
         s = s + {16'h0, w};
      end
      while (s[31:16] != 16'h0) s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
      return ~s[15:0];
   endfunction

   task automatic build_pkt(input logic [7:0] typ, input logic [7:0] code,
                            input logic [15:0] id, input logic [15:0] seq, input int n);
      logic [15:0] cs;
      pkt[0] = typ;  pkt[1] = code; pkt[2] = 8'h00; pkt[3] = 8'h00;
      pkt[4] = id[15:8];  pkt[5] = id[7:0];
      pkt[6] = seq[15:8]; pkt[7] = seq[7:0];
      for (int i = 8; i < n; i++) pkt[i] = 8'($urandom_range(0, 255));
      cs = inet_csum(n);
      pkt[2] = cs[15:8];
      pkt[3] = cs[7:0];
      pkt_n = n;
   endtask

   task automatic set_user(input logic [15:0] len, input bit mf, input logic [7:0] proto,
                           input logic [12:0] off);
      pkt_user = {len, 2'b00, mf, proto, off, 16'h5A5A};
   endtask

   // Drive beats [first, first+cnt) of the packet; returns at the negedge where
   // the final beat was presented (it transfers on the following posedge)
   task automatic send_pkt(input int first, input int cnt);
      int nbeats, b, stall, idx;
      nbeats = (pkt_n + 7) / 8;
      b = 0;
      stall = 0;
      while (b < cnt) begin
         @(negedge i_clk);
         if (bubbles && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_user  = pkt_user;
            s_last  = (first + b == nbeats - 1);
            for (int k = 0; k < 8; k++) begin
               idx = (first + b) * 8 + k;
               s_data[63-8*k -: 8] = (idx < pkt_n) ? pkt[idx] : 8'hA5;
               s_keep[7-k]         = (idx < pkt_n);
            end
            if (s_ready) begin
               if (s_last) last_cyc = cyc;
               b++;
               stall = 0;
            end else begin
               stall++;
               if (stall > 200) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL ready_timeout: actual ready=0 for 200 cycles required 1");
                  b = cnt;
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge i_clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic push_exp(input bit trig, input logic [15:0] id, input logic [15:0] seq);
      exp_t e;
      e.trig = trig; e.id = id; e.seq = seq;
      sb_q.push_back(e);
   endtask

   // Pop the expected outcome when the DUT signals a trigger or a drop
   task automatic check_event(input bit got_trig);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_unexpected: actual %s event required none", got_trig ? "trigger" : "drop");
      end else begin
         e = sb_q.pop_front();
         chk("event_kind", {31'b0, got_trig}, {31'b0, e.trig});
         if (got_trig) begin
            exp_rx++;
            last_id = e.id;
            last_seq = e.seq;
         end else begin
            exp_drop++;
         end
         chk("identifier", {16'h0, o_id}, {16'h0, last_id});
         chk("sequence", {16'h0, o_seq}, {16'h0, last_seq});
         chk("rx_cnt", {16'h0, o_rx}, 32'(exp_rx));
         chk("drop_cnt", {16'h0, o_drop}, 32'(exp_drop));
         txn++;
         $display("txn %0d: %s id=%h seq=%h rx=%0d drop=%0d", txn,
                  got_trig ? "trigger" : "drop", o_id, o_seq, o_rx, o_drop);
      end
   endtask

   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            prev_drop = '0;
         end else begin
            if (o_trig) begin
               trig_cyc = cyc;
               check_event(1'b1);
            end
            if (o_drop != prev_drop) begin
               prev_drop = o_drop;
               check_event(1'b0);
            end
         end
      end
   end

   typedef struct {
      string       name;
      logic [7:0]  typ;
      logic [7:0]  code;
      logic [7:0]  proto;
      bit          mf;
      logic [12:0] off;
      logic [15:0] id;
      logic [15:0] seq;
      int          nbytes;
      int          len_adj;
      bit          corrupt;
      bit          bub;
      bit          exp_trig;
   } vec_t;

`ifdef ICMP_RX_CHECKSUM_EN
   localparam bit CORRUPT_TRIG = 1'b0;
`else
   localparam bit CORRUPT_TRIG = 1'b1;
`endif

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{"corrupt",   8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hC001, 16'h0002, 40,   0,    1'b1, 1'b0, CORRUPT_TRIG};
      vecs[1]  = '{"type0",     8'd0, 8'd0, 8'd1,  1'b0, 13'd0, 16'hC002, 16'h0003, 40,   0,    1'b0, 1'b1, 1'b0};
      vecs[2]  = '{"udp",       8'd8, 8'd0, 8'd17, 1'b0, 13'd0, 16'hC003, 16'h0004, 40,   0,    1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"code1",     8'd8, 8'd1, 8'd1,  1'b0, 13'd0, 16'hC004, 16'h0005, 24,   0,    1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"mf",        8'd8, 8'd0, 8'd1,  1'b1, 13'd0, 16'hC005, 16'h0006, 24,   0,    1'b0, 1'b0, 1'b0};
      vecs[5]  = '{"offset",    8'd8, 8'd0, 8'd1,  1'b0, 13'd5, 16'hC006, 16'h0007, 24,   0,    1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"single8",   8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hABCD, 16'h0102, 8,    0,    1'b0, 1'b0, 1'b1};
      vecs[7]  = '{"odd41",     8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hBEEF, 16'h0203, 41,   0,    1'b0, 1'b1, 1'b1};
      vecs[8]  = '{"len48",     8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hC007, 16'h0008, 40,   8,    1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"len4",      8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hC008, 16'h0009, 8,    -4,   1'b0, 1'b0, 1'b0};
      vecs[10] = '{"len1481",   8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'hC009, 16'h000A, 16,   1465, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{"max1480",   8'd8, 8'd0, 8'd1,  1'b0, 13'd0, 16'h7E57, 16'hFFFE, 1480, 0,    1'b0, 1'b1, 1'b1};

      // Reset state
      #1;
      chk("rst_ready", {31'b0, s_ready}, 32'd0);
      chk("rst_trigger", {31'b0, o_trig}, 32'd0);
      chk("rst_rx_cnt", {16'h0, o_rx}, 32'd0);
      chk("rst_drop_cnt", {16'h0, o_drop}, 32'd0);
      repeat (3) @(posedge i_clk);
      #2 i_rst = 1'b0;

      // 40-byte echo request, trigger latency
      build_pkt(8'd8, 8'd0, 16'h1234, 16'h0001, 40);
      set_user(16'd40, 1'b0, 8'd1, 13'd0);
      push_exp(1'b1, 16'h1234, 16'h0001);
      send_pkt(0, 5);
      idle(12);
      chk("trig_latency", 32'(trig_cyc - last_cyc), 32'd4);
      chk("rx_after_first", {16'h0, o_rx}, 32'd1);

      // Table-driven packets
      for (int v = 0; v < 12; v++) begin
         bubbles = vecs[v].bub;
         build_pkt(vecs[v].typ, vecs[v].code, vecs[v].id, vecs[v].seq, vecs[v].nbytes);
         if (vecs[v].corrupt) pkt[20] = pkt[20] ^ 8'h10;
         set_user(16'(vecs[v].nbytes + vecs[v].len_adj), vecs[v].mf, vecs[v].proto, vecs[v].off);
         push_exp(vecs[v].exp_trig, vecs[v].id, vecs[v].seq);
         send_pkt(0, (vecs[v].nbytes + 7) / 8);
         idle(16);
         chk({"sb_drained_", vecs[v].name}, 32'(sb_q.size()), 32'd0);
      end
      bubbles = 1'b0;

      // Back-to-back requests inside the reply window: second is dropped
      build_pkt(8'd8, 8'd0, 16'h1111, 16'h0011, 8);
      set_user(16'd8, 1'b0, 8'd1, 13'd0);
      push_exp(1'b1, 16'h1111, 16'h0011);
      send_pkt(0, 1);
      build_pkt(8'd8, 8'd0, 16'h2222, 16'h0022, 8);
      push_exp(1'b0, 16'h2222, 16'h0022);
      send_pkt(0, 1);
      idle(16);
      // Same pair with the window allowed to expire: both trigger
      build_pkt(8'd8, 8'd0, 16'h3333, 16'h0033, 8);
      push_exp(1'b1, 16'h3333, 16'h0033);
      send_pkt(0, 1);
      idle(16);
      build_pkt(8'd8, 8'd0, 16'h4444, 16'h0044, 8);
      push_exp(1'b1, 16'h4444, 16'h0044);
      send_pkt(0, 1);
      idle(16);
      chk("sb_drained_gap", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of a packet; the remainder is a new (bad) packet
      build_pkt(8'd8, 8'd0, 16'h5555, 16'h0055, 40);
      pkt[16] = 8'h77;
      set_user(16'd40, 1'b0, 8'd1, 13'd0);
      send_pkt(0, 2);
      @(posedge i_clk);
      #2;
      s_valid = 1'b0;
      i_rst = 1'b1;
      sb_q.delete();
      exp_rx = 0;
      exp_drop = 0;
      last_id = '0;
      last_seq = '0;
      #1;
      chk("midrst_ready", {31'b0, s_ready}, 32'd0);
      chk("midrst_rx_cnt", {16'h0, o_rx}, 32'd0);
      chk("midrst_drop_cnt", {16'h0, o_drop}, 32'd0);
      chk("midrst_id", {16'h0, o_id}, 32'd0);
      chk("midrst_seq", {16'h0, o_seq}, 32'd0);
      @(posedge i_clk);
      #2 i_rst = 1'b0;
      push_exp(1'b0, 16'h0, 16'h0);
      send_pkt(2, 3);
      idle(12);
      chk("sb_drained_rst", 32'(sb_q.size()), 32'd0);
      chk("final_drop_cnt", {16'h0, o_drop}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
